// File: rtl/serial_word_framer.sv
// serial_word_framer
// Deserialises a 1-bit stream (MSB first) into WIDTH-bit words and hands each
// word downstream through a one-entry valid/ready buffer. Alongside each word
// it registers all-ones / all-zeros flags, keeps a saturating count of
// consecutive all-ones words, and raises a sticky overflow flag when a
// completed word has nowhere to go.

module serial_word_framer #(
  parameter int WIDTH = 8,
  parameter int RUN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             all_ones,
  output logic             all_zeros,
  output logic [RUN_W-1:0] ones_run,
  output logic             overflow,
  input  logic             overflow_clr
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] bitcnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] completed;
  logic             complete;
  logic             buf_free;
  logic             load;
  logic             drop;

  // A word completes on the last bit of a frame; sync restarts framing, so a
  // bit sampled together with sync can never complete a word.
  always_comb begin
    completed = {shreg[WIDTH-2:0], bit_in};
    complete  = bit_valid && !sync && (bitcnt == LAST_BIT);
    buf_free  = !word_valid || word_ready;
    load      = complete && buf_free;
    drop      = complete && !buf_free;
  end

  // Shift register and bit counter; sync discards the partial word and, with
  // a valid bit in the same cycle, that bit starts the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt <= '0;
      shreg  <= '0;
    end else if (sync) begin
      if (bit_valid) begin
        bitcnt <= CNT_W'(1);
        shreg  <= {{(WIDTH-1){1'b0}}, bit_in};
      end else begin
        bitcnt <= '0;
        shreg  <= '0;
      end
    end else if (bit_valid) begin
      shreg <= {shreg[WIDTH-2:0], bit_in};
      if (bitcnt == LAST_BIT) begin
        bitcnt <= '0;
      end else begin
        bitcnt <= bitcnt + CNT_W'(1);
      end
    end
  end

  // One-entry output buffer: loads a completed word when free, otherwise
  // holds; a consume without a new word only drops word_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      all_ones   <= 1'b0;
      all_zeros  <= 1'b0;
      ones_run   <= '0;
    end else if (load) begin
      word_out   <= completed;
      word_valid <= 1'b1;
      all_ones   <= &completed;
      all_zeros  <= ~|completed;
      if (&completed) begin
        if (ones_run != {RUN_W{1'b1}}) begin
          ones_run <= ones_run + RUN_W'(1);
        end
      end else begin
        ones_run <= '0;
      end
    end else if (word_valid && word_ready) begin
      word_valid <= 1'b0;
    end
  end

  // Sticky overflow: a drop wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule
